mlaccel_cmdqueue: RTL and testbench
===================================

// Module: mlaccel_cmdqueue
// PURPOSE
//  Byte-stream command front end for mlaccel_compute. Assembles 8-bit host bytes into
//  32-bit instruction words, buffers them in a FIFO, and issues them over the compute
//  cmd_valid/cmd_ready/cmd_insn handshake. Executes the Sync opcode locally: Sync is
//  never forwarded; it drains the compute pipeline before later instructions issue.
// PARAMETERS
//  DEPTH  16  FIFO depth in 32-bit words; power of two, >= 2
//  AW     $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//  clock         in   1     single clock, all logic on posedge
//  reset         in   1     synchronous, active-high
//  in_valid      in   1     host byte valid
//  in_ready      out  1     byte accepted when in_valid && in_ready
//  in_data       in   8     host byte; little-endian, byte 0 = insn[7:0]
//  cmd_valid     out  1     to compute cmd_valid
//  cmd_ready     in   1     from compute cmd_ready
//  cmd_insn      out  32    to compute cmd_insn
//  compute_busy  in   1     from compute busy
//  level         out  AW+1  words currently in FIFO (incl. head, incl. Sync words)
//  idle          out  1     FIFO empty, no partial word, state ISSUE, compute_busy low
// BEHAVIOUR
//  Reset: in_ready=1, cmd_valid=0, level=0, byte_cnt=0, state=ISSUE, issued_q=0. Reset
//   mid-word discards the partial word and all FIFO contents.
//  Assembly: 2-bit byte_cnt, 24-bit shift reg. in_ready = !(byte_cnt==3 && full).
//   Bytes 0..2 are always accepted. Byte 3 push = {in_data, sreg}; byte_cnt wraps to 0.
//  FIFO: first-word-fall-through; a word pushed at cycle N is at the head (visible on
//   cmd_insn) at N+1 if the FIFO was empty. full = (level==DEPTH). No write bypass:
//   a push when full is impossible by the in_ready rule, even if a pop occurs the same cycle.
//   Simultaneous push+pop leaves level unchanged. Pointers wrap modulo DEPTH.
//  Opcode = head[5:0]. SYNC = 6'd0; all other opcodes are forwarded unmodified.
//  FSM:
//   ISSUE: head non-Sync: cmd_valid=!empty; pop on cmd_valid && cmd_ready.
//          head Sync: cmd_valid=0 -> SYNC_WAIT.
//   SYNC_WAIT: cmd_valid=0. Pop Sync when compute_busy==0 && issued_q==0 -> ISSUE.
//  issued_q: registered (cmd_valid && cmd_ready). It covers the one-cycle gap before the
//   compute s1_en/busy rises after acceptance.
//  Back-to-back: one insn per cycle while cmd_ready=1. cmd_insn is stable while
//   cmd_valid && !cmd_ready (head is not popped).
//  Consecutive Syncs: each costs >= 1 cycle in SYNC_WAIT; no forward progress is lost.
//  cmd_valid never depends combinationally on cmd_ready (no loop with compute's stall).
// STRUCTURE
//  Package mlaccel_pkg: opcode localparams (OP_SYNC=0, OP_LOADCODE=4, OP_MACC=40, ...),
//   insn field slices (maddr [31:15], caddr [14:6], opcode [5:0]), FSM state enum.
//  Sub-module mlaccel_fifo #(WIDTH=32, DEPTH): FWFT, push/pop/full/empty/level, sync
//   reset. Top level holds the byte assembler and the Sync FSM.
// TESTING
//  1. Bytes 04 03 02 01 with cmd_ready=1 -> cmd_insn=32'h01020304 with cmd_valid
//     1 cycle after byte 3 is accepted; level returns to 0.
//  2. Fill 16 words with cmd_ready=0 -> level=16; in_ready drops only at byte 3 of word 17.
//     Raise cmd_ready -> 16 insns issue in order, 1 per cycle; pointers wrap correctly.
//  3. Sequence MACC(0x28), SYNC(0x00), Store(0x10). Hold compute_busy=1 for 6 cycles
//     after MACC is accepted -> Store is not valid until the cycle after busy==0.
//     Sync never appears on cmd_insn.
//  4. SYNC accepted while busy is still 0 in the cycle after an issue -> issued_q
//     blocks the pop for that cycle.
//  5. Compute stall: cmd_ready=0 for 3 cycles with cmd_valid=1 -> cmd_insn is constant.
//     Push+pop in the same cycle -> level is unchanged.
//  6. Reset after 2 bytes and 3 queued words -> level=0, cmd_valid=0. The next 4 bytes
//     form a fresh word.

Source files
------------

// File: rtl/mlaccel_pkg.sv
// Shared opcodes, instruction field helpers and front-end FSM encodings for mlaccel.
package mlaccel_pkg;

    localparam logic [5:0] OP_SYNC     = 6'd0;
    localparam logic [5:0] OP_LOADCODE = 6'd4;
    localparam logic [5:0] OP_STORE    = 6'd16;
    localparam logic [5:0] OP_MACC     = 6'd40;

    localparam logic [0:0] ST_ISSUE     = 1'b0;
    localparam logic [0:0] ST_SYNC_WAIT = 1'b1;

    function automatic logic [5:0] insn_opcode(input logic [31:0] insn);
        return insn[5:0];
    endfunction

    function automatic logic [8:0] insn_caddr(input logic [31:0] insn);
        return insn[14:6];
    endfunction

    function automatic logic [16:0] insn_maddr(input logic [31:0] insn);
        return insn[31:15];
    endfunction

endpackage

// File: rtl/mlaccel_fifo.sv
// First-word-fall-through FIFO; head is valid whenever empty is low.
module mlaccel_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_L);
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; not reset, contents are only meaningful below count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mlaccel_cmdqueue.sv
// Byte-stream command front end: assembles words, queues them, executes Sync locally.
module mlaccel_cmdqueue
    import mlaccel_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [31:0]   cmd_insn,
    input  logic          compute_busy,
    output logic [AW:0]   level,
    output logic          idle
);

    logic [1:0]  byte_cnt;
    logic [23:0] sreg;
    logic [0:0]  state;
    logic        issued_q;
    logic        accept;
    logic        push;
    logic        pop;
    logic        sync_pop;
    logic        head_is_sync;
    logic        full;
    logic        empty;
    logic [31:0] head;

    assign in_ready     = !((byte_cnt == 2'd3) && full);
    assign accept       = in_valid && in_ready;
    assign push         = accept && (byte_cnt == 2'd3);
    assign head_is_sync = (insn_opcode(head) == OP_SYNC);

    // cmd_valid is built only from registered state and FIFO status, never cmd_ready.
    assign cmd_valid    = (state == ST_ISSUE) && !empty && !head_is_sync;
    assign cmd_insn     = head;
    assign sync_pop     = (state == ST_SYNC_WAIT) && !compute_busy && !issued_q;
    assign pop          = (cmd_valid && cmd_ready) || sync_pop;
    assign idle         = empty && (byte_cnt == 2'd0) && (state == ST_ISSUE) && !compute_busy;

    mlaccel_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({in_data, sreg}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // Byte assembler: little-endian shift register, byte 3 completes the word.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt <= '0;
            sreg     <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            sreg     <= {in_data, sreg[23:8]};
        end
    end

    // Sync FSM: park on a Sync head until compute has drained, then discard it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_ISSUE;
        end else begin
            case (state)
                ST_ISSUE:     if (!empty && head_is_sync) state <= ST_SYNC_WAIT;
                ST_SYNC_WAIT: if (sync_pop) state <= ST_ISSUE;
                default:      state <= ST_ISSUE;
            endcase
        end
    end

    // Remember an acceptance for one cycle, before compute busy can reflect it.
    always_ff @(posedge clock) begin
        if (reset) begin
            issued_q <= 1'b0;
        end else begin
            issued_q <= cmd_valid && cmd_ready;
        end
    end

endmodule

// File: tb/tb_mlaccel_cmdqueue.sv
// Directed self-checking bench for mlaccel_cmdqueue.
module tb_mlaccel_cmdqueue;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_insn;
    logic        compute_busy;
    logic [4:0]  level;
    logic        idle;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam logic [31:0] W_MACC  = 32'h0001_8028;
    localparam logic [31:0] W_SYNC  = 32'h1234_5640;
    localparam logic [31:0] W_STORE = 32'hCAFE_0010;

    mlaccel_cmdqueue #(.DEPTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_insn     (cmd_insn),
        .compute_busy (compute_busy),
        .level        (level),
        .idle         (idle)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w[8*i +: 8];
            step();
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] fill_word(input int unsigned i);
        return {8'hA0, 8'(i), 8'h5A, 8'h04};
    endfunction

    initial begin
        logic [31:0] w17;
        logic [31:0] wx;
        logic [31:0] wy;

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        cmd_ready    = 1'b1;
        compute_busy = 1'b0;
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        reset = 1'b0;
        step();
        check("rst_idle", 32'(idle), 32'd1);

        // 1. single word, issued one cycle after byte 3
        send_word(32'h0102_0304);
        check("t1_valid", 32'(cmd_valid), 32'd1);
        check("t1_insn", cmd_insn, 32'h0102_0304);
        check("t1_level", 32'(level), 32'd1);
        step();
        check("t1_level_after", 32'(level), 32'd0);
        check("t1_valid_after", 32'(cmd_valid), 32'd0);
        check("t1_idle", 32'(idle), 32'd1);

        // 2. fill to DEPTH, 17th word stalls on byte 3, then drain in order
        cmd_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_word(fill_word(i));
        check("t2_level_full", 32'(level), 32'd16);
        w17 = fill_word(16);
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_data  = w17[8*b +: 8];
            check("t2_in_ready_b012", 32'(in_ready), 32'd1);
            step();
        end
        in_data = w17[31:24];
        check("t2_in_ready_b3", 32'(in_ready), 32'd0);
        cmd_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            check("t2_valid", 32'(cmd_valid), 32'd1);
            check("t2_insn", cmd_insn, fill_word(k));
            step();
            if (k == 1) in_valid = 1'b0;
            check("t2_level", 32'(level), (k == 0) ? 32'd15 : 32'(16 - k));
        end
        check("t2_drained_valid", 32'(cmd_valid), 32'd0);

        // 3. MACC, SYNC, STORE with compute busy after MACC
        cmd_ready = 1'b0;
        send_word(W_MACC);
        send_word(W_SYNC);
        send_word(W_STORE);
        check("t3_level", 32'(level), 32'd3);
        check("t3_macc_insn", cmd_insn, W_MACC);
        cmd_ready = 1'b1;
        step();
        compute_busy = 1'b1;
        check("t3_sync_hidden", 32'(cmd_valid), 32'd0);
        check("t3_level2", 32'(level), 32'd2);
        repeat (6) begin
            step();
            check("t3_wait_busy", 32'(cmd_valid), 32'd0);
        end
        compute_busy = 1'b0;
        check("t3_wait_edge", 32'(cmd_valid), 32'd0);
        step();
        check("t3_store_valid", 32'(cmd_valid), 32'd1);
        check("t3_store_insn", cmd_insn, W_STORE);
        check("t3_level1", 32'(level), 32'd1);
        step();
        check("t3_level0", 32'(level), 32'd0);

        // 4. Sync right behind an issue with busy never raised
        cmd_ready = 1'b0;
        send_word(W_MACC);
        send_word(W_SYNC);
        send_word(W_STORE);
        cmd_ready = 1'b1;
        step();
        check("t4_gap0", 32'(cmd_valid), 32'd0);
        step();
        check("t4_gap1", 32'(cmd_valid), 32'd0);
        check("t4_sync_held", 32'(level), 32'd2);
        step();
        check("t4_store_valid", 32'(cmd_valid), 32'd1);
        check("t4_store_insn", cmd_insn, W_STORE);
        step();
        check("t4_level0", 32'(level), 32'd0);

        // 5. stall keeps head stable; push+pop keeps level
        cmd_ready = 1'b0;
        wx = 32'h0BAD_F00D;
        wy = 32'h7777_1111;
        send_word(wx);
        repeat (3) begin
            check("t5_stall_valid", 32'(cmd_valid), 32'd1);
            check("t5_stall_insn", cmd_insn, wx);
            step();
        end
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_data  = wy[8*b +: 8];
            step();
        end
        in_data   = wy[31:24];
        cmd_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        cmd_ready = 1'b0;
        check("t5_pushpop_level", 32'(level), 32'd1);
        check("t5_pushpop_insn", cmd_insn, wy);
        cmd_ready = 1'b1;
        step();
        check("t5_level0", 32'(level), 32'd0);

        // 6. reset mid-word with queued words
        cmd_ready = 1'b0;
        for (int i = 1; i < 4; i++) send_word(fill_word(i));
        in_valid = 1'b1;
        in_data  = 8'hEE;
        step();
        in_data  = 8'hFF;
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        check("t6_level", 32'(level), 32'd0);
        check("t6_valid", 32'(cmd_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        step();
        check("t6_idle", 32'(idle), 32'd1);
        send_word(32'h89AB_CD05);
        check("t6_fresh_level", 32'(level), 32'd1);
        check("t6_fresh_valid", 32'(cmd_valid), 32'd1);
        check("t6_fresh_insn", cmd_insn, 32'h89AB_CD05);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
